// File: rtl/sd_pixel_unpacker_if.sv
// Byte-in / frame-buffer-write bundle for the SD pixel unpacker.
// master drives the byte stream and start; slave is the unpacker.
interface sd_pixel_unpacker_if #(
  parameter int ADDR_W = 17
) ();
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [11:0]       dina;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wea, addra, dina, busy, frame_done
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wea, addra, dina, busy, frame_done
  );
endinterface

// File: rtl/sd_pixel_unpacker.sv
// Skips a fixed file header, unpacks RGB444 byte triplets into two 12-bit pixels
// and writes them to frame buffer port A in raster order.
//
// state | meaning
// IDLE  | waiting for start, byte stream not accepted
// HDR   | discarding file header bytes
// BYTE0 | waiting for first byte of a triplet (P0[11:4])
// BYTE1 | waiting for second byte; completes P0
// BYTE2 | waiting for third byte; completes P1
// DONE  | last pixel written, frame_done follows next cycle
module sd_pixel_unpacker #(
  parameter int FB_PIXELS = 76800,
  parameter int ADDR_W    = 17,
  parameter int HDR_BYTES = 0
) (
  input logic                 clk,
  input logic                 rst,
  sd_pixel_unpacker_if.slave  bus
);

  localparam int HDR_CNT_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam logic [ADDR_W-1:0]    LAST_PIX = ADDR_W'(FB_PIXELS - 1);
  localparam logic [HDR_CNT_W-1:0] LAST_HDR = HDR_CNT_W'(HDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    BYTE0 = 3'd2,
    BYTE1 = 3'd3,
    BYTE2 = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam state_e FIRST_STATE = (HDR_BYTES > 0) ? HDR : BYTE0;

  state_e                state_q, state_d;
  logic [HDR_CNT_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [7:0]            byte0_q, byte0_d;
  logic [3:0]            nib_q, nib_d;
  logic [ADDR_W-1:0]     pix_q, pix_d;
  logic                  wea_q, wea_d;
  logic [ADDR_W-1:0]     addra_q, addra_d;
  logic [11:0]           dina_q, dina_d;
  logic                  fd_q, fd_d;
  logic                  in_ready;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_cnt_q <= '0;
      byte0_q   <= '0;
      nib_q     <= '0;
      pix_q     <= '0;
      wea_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      byte0_q   <= byte0_d;
      nib_q     <= nib_d;
      pix_q     <= pix_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      fd_q      <= fd_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == HDR) || (state_q == BYTE0) ||
                (state_q == BYTE1) || (state_q == BYTE2);
    accept    = bus.in_valid && in_ready;
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    byte0_d   = byte0_q;
    nib_d     = nib_q;
    pix_d     = pix_q;
    wea_d     = 1'b0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    fd_d      = (state_q == DONE);

    // start wins over a byte offered in the same cycle: the partial pixel is dropped
    if (bus.start) begin
      state_d   = FIRST_STATE;
      hdr_cnt_d = '0;
      pix_d     = '0;
    end else begin
      case (state_q)
        HDR: begin
          if (accept) begin
            if (hdr_cnt_q == LAST_HDR) begin
              hdr_cnt_d = '0;
              state_d   = BYTE0;
            end else begin
              hdr_cnt_d = hdr_cnt_q + 1'b1;
            end
          end
        end
        BYTE0: begin
          if (accept) begin
            byte0_d = bus.in_data;
            state_d = BYTE1;
          end
        end
        BYTE1: begin
          if (accept) begin
            wea_d   = 1'b1;
            addra_d = pix_q;
            dina_d  = {byte0_q, bus.in_data[7:4]};
            nib_d   = bus.in_data[3:0];
            pix_d   = pix_q + 1'b1;
            state_d = BYTE2;
          end
        end
        BYTE2: begin
          if (accept) begin
            wea_d   = 1'b1;
            addra_d = pix_q;
            dina_d  = {nib_q, bus.in_data};
            pix_d   = pix_q + 1'b1;
            state_d = (pix_q == LAST_PIX) ? DONE : BYTE0;
          end
        end
        DONE: begin
          pix_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  // a write registered just before reset must not reach the frame buffer
  assign bus.wea        = wea_q & ~rst;
  assign bus.addra      = addra_q;
  assign bus.dina       = dina_q;
  assign bus.busy       = (state_q != IDLE) || fd_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sd_pixel_unpacker.sv
// Bench for sd_pixel_unpacker: two instances (no header / 4-byte header, short
// frame) checked every cycle against a byte-count based reference model.
module tb_sd_pixel_unpacker;
  localparam int AW    = 17;
  localparam int FB_A  = 76800;
  localparam int HDR_A = 0;
  localparam int FB_B  = 120;
  localparam int HDR_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_pixel_unpacker_if #(.ADDR_W(AW)) ifa ();
  sd_pixel_unpacker_if #(.ADDR_W(AW)) ifb ();

  sd_pixel_unpacker #(.FB_PIXELS(FB_A), .ADDR_W(AW), .HDR_BYTES(HDR_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  sd_pixel_unpacker #(.FB_PIXELS(FB_B), .ADDR_W(AW), .HDR_BYTES(HDR_B)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 receiving, 2 last pixel written
  int         ph     [2];
  int         cnt    [2];
  int         m_addr [2];
  int         m_dat  [2];
  bit         m_wea  [2];
  bit         m_fd   [2];
  logic [7:0] mem    [2][0:1023];
  int         hdr_of [2] = '{HDR_A, HDR_B};
  int         fb_of  [2] = '{FB_A, FB_B};
  int         cyc_n  = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    for (int d = 0; d < 2; d++) begin
      logic       st, vld, acc;
      logic [7:0] din;
      int         n, pix;
      st  = (d == 0) ? ifa.start    : ifb.start;
      vld = (d == 0) ? ifa.in_valid : ifb.in_valid;
      din = (d == 0) ? ifa.in_data  : ifb.in_data;
      if (rst) begin
        ph[d] = 0; cnt[d] = 0; m_addr[d] = 0; m_dat[d] = 0;
        m_wea[d] = 1'b0; m_fd[d] = 1'b0;
      end else begin
        acc      = vld && (ph[d] == 1);
        m_fd[d]  = (ph[d] == 2);
        m_wea[d] = 1'b0;
        if (st) begin
          ph[d]  = 1;
          cnt[d] = 0;
        end else if (ph[d] == 2) begin
          ph[d] = 0;
        end else if (acc) begin
          if (cnt[d] >= hdr_of[d]) begin
            n = cnt[d] - hdr_of[d] + 1;
            mem[d][(n - 1) % 1024] = din;
            pix = -1;
            if (n % 3 == 2) begin
              pix = (n / 3) * 2;
              m_dat[d] = {20'd0, mem[d][(n - 2) % 1024], mem[d][(n - 1) % 1024][7:4]};
            end else if (n % 3 == 0) begin
              pix = (n / 3) * 2 - 1;
              m_dat[d] = {20'd0, mem[d][(n - 2) % 1024][3:0], mem[d][(n - 1) % 1024]};
            end
            if (pix >= 0) begin
              m_wea[d]  = 1'b1;
              m_addr[d] = pix;
              if (pix == fb_of[d] - 1) ph[d] = 2;
            end
          end
          cnt[d]++;
        end
      end
    end
  end

  int wr_cnt   [2];
  int wr_addr  [2][0:3];
  int wr_dat   [2][0:3];
  int wr_cyc   [2][0:3];
  int last_addr[2];
  int last_cyc [2];
  int fd_cnt   [2];
  int fd_cyc   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic          o_rdy, o_busy, o_fd, o_wea;
      logic [AW-1:0] o_addr;
      logic [11:0]   o_dat;
      string         p;
      p      = (d == 0) ? "a_" : "b_";
      o_rdy  = (d == 0) ? ifa.in_ready   : ifb.in_ready;
      o_busy = (d == 0) ? ifa.busy       : ifb.busy;
      o_fd   = (d == 0) ? ifa.frame_done : ifb.frame_done;
      o_wea  = (d == 0) ? ifa.wea        : ifb.wea;
      o_addr = (d == 0) ? ifa.addra      : ifb.addra;
      o_dat  = (d == 0) ? ifa.dina       : ifb.dina;
      check_val({p, "in_ready"}, 32'(o_rdy), 32'(ph[d] == 1));
      check_val({p, "busy"}, 32'(o_busy), 32'(ph[d] != 0 || m_fd[d]));
      check_val({p, "frame_done"}, 32'(o_fd), 32'(m_fd[d]));
      check_val({p, "wea"}, 32'(o_wea), 32'(m_wea[d] && !rst));
      check_val({p, "addra"}, 32'(o_addr), 32'(m_addr[d]));
      check_val({p, "dina"}, 32'(o_dat), 32'(m_dat[d]));
      if (o_wea === 1'b1) begin
        if (wr_cnt[d] < 4) begin
          wr_addr[d][wr_cnt[d]] = int'(o_addr);
          wr_dat[d][wr_cnt[d]]  = int'(o_dat);
          wr_cyc[d][wr_cnt[d]]  = cyc_n;
        end
        last_addr[d] = int'(o_addr);
        last_cyc[d]  = cyc_n;
        wr_cnt[d]++;
      end
      if (o_fd === 1'b1) begin
        fd_cnt[d]++;
        fd_cyc[d] = cyc_n;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit st, input bit vld, input logic [7:0] dat);
    if (d == 0) begin
      ifa.start = st; ifa.in_valid = vld; ifa.in_data = dat;
    end else begin
      ifb.start = st; ifb.in_valid = vld; ifb.in_data = dat;
    end
  endtask

  task automatic cyc(input int d, input bit st, input bit vld, input logic [7:0] dat);
    drive(d, st, vld, dat);
    tick();
    drive(d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log(input int d);
    wr_cnt[d] = 0;
    fd_cnt[d] = 0;
    for (int i = 0; i < 4; i++) begin
      wr_addr[d][i] = -1; wr_dat[d][i] = -1; wr_cyc[d][i] = -1;
    end
  endtask

  initial begin
    int sent, w;
    logic [7:0] hdr_pat [0:6];
    hdr_pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'hCD, 8'hEF};
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    clear_log(0);
    clear_log(1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_val("rst_busy", 32'(ifa.busy), 32'd0);
    check_val("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    check_val("rst_addra", 32'(ifa.addra), 32'd0);
    check_val("rst_dina", 32'(ifa.dina), 32'd0);

    // no header: AB CD EF -> two back-to-back writes
    clear_log(0);
    cyc(0, 1'b1, 1'b0, 8'h00);
    cyc(0, 1'b0, 1'b1, 8'hAB);
    cyc(0, 1'b0, 1'b1, 8'hCD);
    cyc(0, 1'b0, 1'b1, 8'hEF);
    repeat (3) tick();
    check_val("t1_count", 32'(wr_cnt[0]), 32'd2);
    check_val("t1_addr0", 32'(wr_addr[0][0]), 32'd0);
    check_val("t1_dat0", 32'(wr_dat[0][0]), 32'hABC);
    check_val("t1_addr1", 32'(wr_addr[0][1]), 32'd1);
    check_val("t1_dat1", 32'(wr_dat[0][1]), 32'hDEF);
    check_val("t1_adjacent", 32'(wr_cyc[0][1] - wr_cyc[0][0]), 32'd1);

    // 4-byte header is dropped
    clear_log(1);
    cyc(1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1, 1'b0, 1'b1, hdr_pat[i]);
    repeat (3) tick();
    check_val("t2_count", 32'(wr_cnt[1]), 32'd2);
    check_val("t2_addr0", 32'(wr_addr[1][0]), 32'd0);
    check_val("t2_dat0", 32'(wr_dat[1][0]), 32'hABC);
    check_val("t2_dat1", 32'(wr_dat[1][1]), 32'hDEF);

    // full short frame with random bubbles (restarts the half-filled frame above)
    cyc(1, 1'b1, 1'b0, 8'h00);
    clear_log(1);
    sent = 0;
    while (sent < HDR_B + FB_B * 3 / 2) begin
      if ($urandom_range(0, 2) != 0) begin
        cyc(1, 1'b0, 1'b1, 8'($urandom));
        sent++;
      end else begin
        cyc(1, 1'b0, 1'b0, 8'($urandom));
      end
    end
    w = 0;
    while (fd_cnt[1] == 0 && w < 50) begin
      tick();
      w++;
    end
    check_val("t3_done_seen", 32'(fd_cnt[1]), 32'd1);
    check_val("t3_writes", 32'(wr_cnt[1]), 32'(FB_B));
    check_val("t3_last_addr", 32'(last_addr[1]), 32'(FB_B - 1));
    check_val("t3_done_after_last", 32'(fd_cyc[1] - last_cyc[1]), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1, 1'b0, 1'b1, 8'($urandom));
    check_val("t3_done_single", 32'(fd_cnt[1]), 32'd1);
    check_val("t3_no_extra_writes", 32'(wr_cnt[1]), 32'(FB_B));
    check_val("t3_idle_busy", 32'(ifb.busy), 32'd0);
    check_val("t3_idle_ready", 32'(ifb.in_ready), 32'd0);

    // restart after 5 bytes drops the orphan partial pixel
    cyc(0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1, 8'($urandom));
    cyc(0, 1'b1, 1'b0, 8'h00);
    clear_log(0);
    cyc(0, 1'b0, 1'b1, 8'hAB);
    cyc(0, 1'b0, 1'b1, 8'hCD);
    cyc(0, 1'b0, 1'b1, 8'hEF);
    repeat (3) tick();
    check_val("t4_count", 32'(wr_cnt[0]), 32'd2);
    check_val("t4_addr0", 32'(wr_addr[0][0]), 32'd0);
    check_val("t4_dat0", 32'(wr_dat[0][0]), 32'hABC);

    // reset right after a b1 accept: the pending write never appears
    cyc(0, 1'b1, 1'b0, 8'h00);
    cyc(0, 1'b0, 1'b1, 8'h12);
    clear_log(0);
    drive(0, 1'b0, 1'b1, 8'h34);
    tick();
    drive(0, 1'b0, 1'b1, 8'h56);
    rst = 1'b1;
    repeat (3) tick();
    check_val("t5_no_write", 32'(wr_cnt[0]), 32'd0);
    check_val("t5_busy", 32'(ifa.busy), 32'd0);
    rst = 1'b0;

    // idle with in_valid high and no start
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b0, 1'b1, 8'($urandom));
      tick();
      check_val("t6_ready", 32'(ifa.in_ready), 32'd0);
    end
    drive(0, 1'b0, 1'b0, 8'h00);
    tick();
    check_val("t6_no_write", 32'(wr_cnt[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
